// File: rtl/binary_tree_feed_ctrl.sv
// Feed/mix/flush sequencer for two 4-inlet binary mixer trees; first valve opens one cycle after start.
// No backpressure: start is taken only in IDLE, abort only in FILL/MIX; all drives decode from registered state.
module binary_tree_feed_ctrl #(
   parameter int FILL_CYCLES  = 16,
   parameter int MIX_CYCLES   = 64,
   parameter int FLUSH_CYCLES = 8,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] inlet_mask,
   input  logic       abort,
   output logic [7:0] valve_en,
   output logic [1:0] mix_en,
   output logic       flush_en,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic [2:0] cur_inlet
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_MIX   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYCLES - 1);
   localparam logic [CNT_W-1:0] MIX_LD   = CNT_W'(MIX_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [7:0]       mask_q, mask_d;
   logic [7:0]       pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             abort_q, abort_d;

   logic [7:0]       cur_oh;
   logic [7:0]       pend_rest;
   logic [2:0]       cur_idx;
   logic             cnt_last;

   // pend_q holds the inlets not yet finished; its lowest set bit is the open valve
   assign cur_oh    = pend_q & (~pend_q + 8'd1);
   assign pend_rest = pend_q & ~cur_oh;
   assign cnt_last  = (cnt_q == '0);

   always_comb begin
      cur_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pend_q[i]) cur_idx = 3'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         pend_q  <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      case (state_q)
         S_IDLE: begin
            abort_d = 1'b0;
            if (start && (inlet_mask != 8'd0)) begin
               state_d = S_FILL;
               mask_d  = inlet_mask;
               pend_d  = inlet_mask;
               cnt_d   = FILL_LD;
            end
         end
         S_FILL: begin
            // abort wins over a counter expiring in the same cycle
            if (abort) begin
               state_d = S_FLUSH;
               pend_d  = '0;
               cnt_d   = FLUSH_LD;
               abort_d = 1'b1;
            end else if (cnt_last) begin
               pend_d = pend_rest;
               if (pend_rest != 8'd0) begin
                  cnt_d = FILL_LD;
               end else begin
                  state_d = S_MIX;
                  cnt_d   = MIX_LD;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_MIX: begin
            if (abort || cnt_last) begin
               state_d = S_FLUSH;
               cnt_d   = FLUSH_LD;
               abort_d = abort_q | abort;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_FLUSH: begin
            if (cnt_last) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            abort_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            pend_d  = '0;
            cnt_d   = '0;
            abort_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      valve_en  = 8'd0;
      mix_en    = 2'b00;
      flush_en  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      aborted   = 1'b0;
      cur_inlet = 3'd0;
      case (state_q)
         S_FILL: begin
            valve_en  = cur_oh;
            cur_inlet = cur_idx;
            busy      = 1'b1;
         end
         S_MIX: begin
            mix_en = {|mask_q[7:4], |mask_q[3:0]};
            busy   = 1'b1;
         end
         S_FLUSH: begin
            flush_en = 1'b1;
            busy     = 1'b1;
         end
         S_DONE: begin
            done    = 1'b1;
            aborted = abort_q;
         end
         default: ;
      endcase
   end

   a_drive_excl: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({|valve_en, |mix_en, flush_en}));
   a_valve_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(valve_en));

endmodule

// File: doc/binary_tree_feed_ctrl.md
BINARY_TREE_FEED_CTRL -- requirements
Module: binary_tree_feed_ctrl

Interface
REQ-001 SHALL have parameter FILL_CYCLES, default 16: cycles each selected inlet valve stays open.
REQ-002 SHALL have parameter MIX_CYCLES, default 64: cycles the mixer trees are actuated.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 8: cycles the flush valve stays open.
REQ-004 SHALL have parameter CNT_W, default 8: phase-counter width; all *_CYCLES values SHALL be 1..2^CNT_W-1.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: request one feed/mix/flush run.
REQ-008 SHALL have port inlet_mask, input, 8: inlets to load; bits 0-3 feed tree 0, bits 4-7 feed tree 1.
REQ-009 SHALL have port abort, input, 1: terminate the current run.
REQ-010 SHALL have port valve_en, output, 8: inlet valve drive, one-hot or zero.
REQ-011 SHALL have port mix_en, output, 2: per-tree mixer actuation.
REQ-012 SHALL have port flush_en, output, 1: flush valve drive.
REQ-013 SHALL have port busy, output, 1: run in progress.
REQ-014 SHALL have port done, output, 1: single-cycle end-of-run pulse.
REQ-015 SHALL have port aborted, output, 1: qualifies done; high when the run ended via abort.
REQ-016 SHALL have port cur_inlet, output, 3: index of the open inlet; 0 when none is open.

Function
REQ-017 SHALL implement states IDLE, FILL, MIX, FLUSH, DONE.
REQ-018 In IDLE, start=1 with inlet_mask!=0 SHALL latch inlet_mask and move to FILL on that edge; start with mask==0 SHALL be ignored.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 FILL SHALL visit latched mask bits in ascending index order, opening exactly one valve per visit for FILL_CYCLES cycles, back-to-back with no gap cycles.
REQ-021 After the last visit, the FSM SHALL enter MIX; the first valve SHALL open in the cycle after start is sampled.
REQ-022 MIX SHALL last MIX_CYCLES cycles with mix_en[0]=|mask[3:0], mix_en[1]=|mask[7:4], and valve_en=0.
REQ-023 FLUSH SHALL last FLUSH_CYCLES cycles with flush_en=1; all other drives SHALL be 0.
REQ-024 DONE SHALL last one cycle with done=1; the FSM SHALL then return to IDLE.
REQ-025 busy SHALL be 1 in FILL, MIX and FLUSH, and 0 in IDLE and DONE.
REQ-026 abort=1 in FILL or MIX SHALL enter FLUSH on the next edge, closing all valves and mixers, and set a sticky abort flag.
REQ-027 abort SHALL be ignored in IDLE, FLUSH and DONE; abort takes priority over phase-counter expiry in the same cycle.
REQ-028 aborted SHALL equal the abort flag during DONE and be 0 otherwise; the flag SHALL clear on entering IDLE.
REQ-029 At most one of {any valve_en, any mix_en, flush_en} SHALL be nonzero in any cycle.
REQ-030 The phase counter SHALL reload on every state or inlet change and SHALL never wrap.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, clear the latched mask, counter and abort flag, and drive all outputs to 0, including mid-run.
REQ-032 After rst_n deasserts, the first start SHALL be honoured at the first rising edge.

Verification
REQ-033 FILL=2, MIX=3, FLUSH=1, mask=0x81, start at cycle 0 -> valve_en=0x01 in cycles 1-2 and 0x80 in cycles 3-4; mix_en=2'b11 in cycles 5-7; flush_en in cycle 8; done=1 with aborted=0 in cycle 9; busy=1 in cycles 1-8.
REQ-034 mask=0x00 with start -> FSM stays IDLE, and busy, done and all drives stay 0.
REQ-035 mask=0x0F, abort during the second inlet -> valve_en goes to 0 the next cycle, FLUSH_CYCLES of flush_en follow, then done=1 with aborted=1; mix_en is never asserted.
REQ-036 start pulsed while busy -> no effect on sequence or timing; a second start in DONE is ignored.
REQ-037 rst_n asserted mid-MIX -> mix_en=0 asynchronously, with no done pulse; a fresh run after release completes normally.
REQ-038 Random masks and aborts -> the REQ-029 exclusivity assertion never fires, and valve_en is always one-hot or zero.
